// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the 5-stage RV32I core.
//   OP_*         : 7-bit major opcodes used by the decode-side logic
//   NOP          : canonical NOP (addi x0,x0,0) held in empty pipeline registers
//   ifid_state_e : IF/ID controller states
package core_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    typedef enum logic [1:0] {RUN, STALL, FLUSH} ifid_state_e;
endpackage

// File: rtl/instruction_parser.sv
// instruction_parser: splits a 32-bit RV32I instruction into its fixed fields.
//   inst   in  32 : instruction word
//   opcode out 7  : [6:0]     rd  out 5 : [11:7]   func3 out 3 : [14:12]
//   rs1    out 5  : [19:15]   rs2 out 5 : [24:20]  func7 out 7 : [31:25]
module instruction_parser (
    input  logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  func7
);
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign func3  = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign func7  = inst[31:25];
endmodule

// File: rtl/src_use_decode.sv
// src_use_decode: which register sources an opcode actually reads.
//   opcode  in  7 : major opcode
//   use_rs1 out 1 : instruction reads rs1
//   use_rs2 out 1 : instruction reads rs2
module src_use_decode import core_pkg::*; (
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2
);
    assign use_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};
    assign use_rs1 = use_rs2 || (opcode inside {OP_I, OP_LOAD, OP_JALR});
endmodule

// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl: IF/ID register owner with load-use stall and redirect flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_inst/valid     : fetched instruction and its valid flag
//   ex_redirect         : taken branch/jump pulse from EX
//   pc_en               : PC write enable
//   if_id_inst/valid    : held instruction and its valid flag
//   id_opcode..id_func7 : fields of if_id_inst
//   id_ex_bubble        : ID/EX must capture a NOP this cycle
//   hazard_stall        : load-use stall active
module if_id_hazard_ctrl import core_pkg::*; #(
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_inst,
    input  logic        imem_valid,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_func3,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [6:0]  id_func7,
    output logic        id_ex_bubble,
    output logic        hazard_stall
);
    ifid_state_e state;
    logic [2:0]  load_cnt;
    logic [4:0]  pend_rd;
    logic [1:0]  flush_cnt;
    logic        use_rs1, use_rs2, hazard, flushing, leave;

    instruction_parser u_parser (
        .inst(if_id_inst), .opcode(id_opcode), .rd(id_rd), .func3(id_func3),
        .rs1(id_rs1), .rs2(id_rs2), .func7(id_func7)
    );

    src_use_decode u_use (.opcode(id_opcode), .use_rs1(use_rs1), .use_rs2(use_rs2));

    assign flushing = state == FLUSH;
    // if_id_valid is always 0 in FLUSH, so hazard cannot fire there
    assign hazard = if_id_valid && load_cnt != 3'd0 && pend_rd != 5'd0 &&
                    ((use_rs1 && id_rs1 == pend_rd) || (use_rs2 && id_rs2 == pend_rd));
    assign leave = if_id_valid && !hazard && !ex_redirect && !flushing;
    assign hazard_stall = hazard && !ex_redirect;
    // rst_n gating keeps the combinational outputs quiet while held in reset
    assign id_ex_bubble = rst_n && (hazard || ex_redirect || flushing);
    assign pc_en = rst_n && (ex_redirect || flushing || (!hazard && imem_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            if_id_inst  <= NOP;
            if_id_valid <= 1'b0;
            load_cnt    <= 3'd0;
            pend_rd     <= 5'd0;
            flush_cnt   <= 2'd0;
        end else begin
            if (ex_redirect) begin
                state       <= FLUSH;
                flush_cnt   <= 2'(FLUSH_CYC - 1);
                if_id_valid <= 1'b0;
            end else if (flushing && flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end else if (hazard) begin
                state <= STALL;
            end else begin
                state       <= RUN;
                if_id_inst  <= imem_inst;
                if_id_valid <= imem_valid;
            end
            if (leave && id_opcode == OP_LOAD && id_rd != 5'd0) begin
                load_cnt <= 3'(LOAD_LAT);
                pend_rd  <= id_rd;
            end else if (load_cnt != 3'd0) begin
                load_cnt <= load_cnt - 3'd1;
            end
        end
    end
endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

Pipeline controller between fetch and decode of the 5-stage RV32I core. It owns the IF/ID instruction register and splits the held instruction into its fields. It detects load-use hazards and stalls fetch and IF/ID until the load result can be forwarded, inserting bubbles into ID/EX while it waits. It squashes wrong-path instructions on a taken branch or jump redirect from EX.

## Interface
- LOAD_LAT, default 1: cycles after a load leaves ID before a dependent instruction may leave ID. Legal range 1–7.
- FLUSH_CYC, default 1: cycles IF/ID stays invalid after a redirect. Legal range 1–3.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_inst  in  32  instruction fetched at current PC
- imem_valid  in  1  imem_inst valid this cycle
- ex_redirect  in  1  one-cycle pulse: taken branch or jump resolved in EX
- pc_en  out  1  PC register write enable
- if_id_inst  out  32  held instruction
- if_id_valid  out  1  held instruction is real, not a bubble
- id_opcode / id_rd / id_func3 / id_rs1 / id_rs2 / id_func7  out  7/5/3/5/5/7  fields of if_id_inst
- id_ex_bubble  out  1  ID/EX must capture a NOP this cycle
- hazard_stall  out  1  load-use stall active (debug/perf counter)

## Operation
- Fields are decoded combinationally from if_id_inst: opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20], func7 [31:25].
- Source-use decode by opcode:
  - uses rs1 and rs2: 0110011, 0100011, 1100011
  - uses rs1 only: 0010011, 0000011, 1100111
  - uses neither: 0110111, 0010111, 1101111, and all others
- Load tracker: 3-bit load_cnt and 5-bit pend_rd.
  - When a valid instruction with opcode 0000011 leaves ID: load_cnt <= LOAD_LAT, pend_rd <= id_rd.
  - Otherwise, while load_cnt != 0, it decrements by 1 each cycle.
  - A load with rd = x0 does not arm the tracker.
- Hazard: if_id_valid & (load_cnt != 0) & pend_rd != 0 & a used source equals pend_rd.
- FSM with states RUN, STALL, FLUSH. Reset state is RUN.
- RUN:
  - ex_redirect → FLUSH, flush_cnt <= FLUSH_CYC−1.
  - else hazard → STALL.
  - else IF/ID <= {imem_inst, imem_valid}.
- STALL:
  - pc_en = 0; IF/ID holds; id_ex_bubble = 1; hazard_stall = 1.
  - Return to RUN on the cycle hazard deasserts (same-cycle evaluation).
  - ex_redirect overrides: go to FLUSH.
- FLUSH:
  - if_id_valid <= 0; id_ex_bubble = 1; pc_en = 1, so the redirected PC is fetched.
  - Decrement flush_cnt; when it is 0, go to RUN and capture imem_inst.
  - A new ex_redirect in FLUSH reloads flush_cnt.
- Priority: redirect > hazard > normal advance.
- A load squashed by a redirect in the same cycle does not arm the tracker.
- An instruction "leaves ID" exactly when if_id_valid & !hazard & !ex_redirect & state != FLUSH.
- imem_valid = 0 in RUN loads a bubble: if_id_valid <= 0, pc_en = 0.

## Timing
- Reset values:
  - if_id_inst = 32'h0000_0013 (NOP), if_id_valid = 0
  - pc_en = 0, id_ex_bubble = 0, hazard_stall = 0
  - load_cnt = 0, pend_rd = 0, flush_cnt = 0, state = RUN
- Reset applies immediately on rst_n falling, including mid-stall or mid-flush. The first capture is on the first rising clk edge with rst_n high.
- All outputs except the decoded fields and id_ex_bubble/pc_en/hazard_stall are registered. Those four are combinational from state, registers and ex_redirect; there is no combinational path from imem_inst.
- With LOAD_LAT=1, a dependent instruction immediately behind a load stalls exactly 1 cycle. With LOAD_LAT=N it stalls N cycles.
- A redirect costs FLUSH_CYC bubbles into ID/EX, plus the instruction squashed in the redirect cycle.

## Structure
- Shared package core_pkg holds:
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - NOP constant 32'h0000_0013
  - enum ifid_state_e {RUN, STALL, FLUSH}
- Instantiate the existing instruction_parser for field extraction.
- One new sub-module, src_use_decode (opcode → use_rs1, use_rs2), shared later with the forwarding unit.

## Test plan
- **Normal advance.** Stream addi x1,x0,5 (00500093), then add x2,x1,x1. → Both leave ID on consecutive cycles; pc_en=1; no bubbles.
- **Load-use, LOAD_LAT=1.** lw x5,0(x0), then add x6,x5,x0. → hazard_stall=1 and id_ex_bubble=1 for exactly 1 cycle; the add leaves ID next.
- **Load with no dependency.** lw x5, then lui x5,1. → No stall, because LUI uses no sources. Also lw x0 followed by add x1,x0,x0 → no stall.
- **Redirect during stall.** Raise ex_redirect in the STALL cycle. → FLUSH for FLUSH_CYC cycles; if_id_valid=0; the stalled add is discarded; pc_en=1.
- **LOAD_LAT=3.** lw x7, then sw x7,0(x1), where the rs2 dependency is via store. → 3 stall cycles, then the sw advances.
- **Async reset mid-FLUSH.** Drop rst_n between clock edges. → Outputs show the reset values immediately; after release the first fetched instruction is captured in RUN.
